// File: rtl/lbist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lbist_pkg
//  Purpose  : Shared LBIST types: FSM state encoding, LFSR taps, MISR polynomial
//             and the single-step MISR function.
//  Revision : 1.0 - initial release
// ============================================================================
package lbist_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SHIFT   = 3'd1,
      S_CAPTURE = 3'd2,
      S_COMPARE = 3'd3,
      S_DONE    = 3'd4
   } lbist_state_t;

   // Right-shifting Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'h002D;
   localparam logic [15:0] MISR_POLY = 16'h1021;

   function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
      return {m[14:0], 1'b0} ^ (m[15] ? MISR_POLY : 16'h0000) ^ d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lbist_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : lbist_sequencer_if
//  Purpose  : Test-access and core-side scan/PI/PO signals of the LBIST sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface lbist_sequencer_if #(
   parameter int PI_W   = 7,
   parameter int PO_W   = 7,
   parameter int MISR_W = 16,
   parameter int PAT_W  = 10
);
   logic              start;
   logic [PAT_W-1:0]  num_patterns;
   logic [MISR_W-1:0] golden;
   logic              scan_en;
   logic              scan_in;
   logic              scan_out;
   logic [PI_W-1:0]   cut_pi;
   logic [PO_W-1:0]   cut_po;
   logic              busy;
   logic              done;
   logic              pass;
   logic [MISR_W-1:0] signature;

   modport master (
      input  start, num_patterns, golden, scan_out, cut_po,
      output scan_en, scan_in, cut_pi, busy, done, pass, signature
   );

   modport slave (
      output start, num_patterns, golden, scan_out, cut_po,
      input  scan_en, scan_in, cut_pi, busy, done, pass, signature
   );
endinterface
`default_nettype wire

// File: rtl/lbist_misr.sv
`default_nettype none
// ============================================================================
//  Module   : lbist_misr
//  Purpose  : Multiple-input signature register with clear and compaction enable.
//  Revision : 1.0 - initial release
// ============================================================================
module lbist_misr
   import lbist_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] sig
);
   logic [W-1:0] r_sig;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_sig <= '0;
      end else if (en) begin
         r_sig <= misr_step(r_sig, din);
      end
   end

   assign sig = r_sig;
endmodule
`default_nettype wire

// File: rtl/lbist_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lbist_sequencer
//  Purpose  : Logic-BIST controller: LFSR patterns into one scan chain, shift/
//             capture sequencing, MISR compaction, golden-signature compare.
//             Option macro LBIST_PO_COMPACT_EN: also compact cut_po in CAPTURE.
//  Revision : 1.0 - initial release
// ============================================================================
module lbist_sequencer
   import lbist_pkg::*;
#(
   parameter int                 CHAIN_LEN = 6,
   parameter int                 PI_W      = 7,
   parameter int                 PO_W      = 7,
   parameter int                 LFSR_W    = 16,
   parameter int                 MISR_W    = 16,
   parameter int                 PAT_W     = 10,
   parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1
) (
   input  logic                  CK,
   input  logic                  RST,
   lbist_sequencer_if.master     bus
);
   localparam int              CNT_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

   lbist_state_t      r_state, w_state_next;
   logic [LFSR_W-1:0] r_lfsr, w_lfsr_next, w_lfsr_stepped;
   logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
   logic [PAT_W:0]    r_pat_idx, w_pat_idx_next;
   logic [PAT_W-1:0]  r_n_lat, w_n_next;
   logic [MISR_W-1:0] r_golden;
   logic              w_accept, w_loading, w_loading_next;
   logic              w_misr_en, w_misr_clr;
   logic [MISR_W-1:0] w_misr_data, w_sig, w_po_data;
   logic              w_po_en;
   logic              r_scan_en, r_scan_in, r_busy, r_done, r_pass;
   logic [PI_W-1:0]   r_cut_pi;

`ifdef LBIST_PO_COMPACT_EN
   assign w_po_en   = 1'b1;
   assign w_po_data = MISR_W'(bus.cut_po);
`else
   logic [PO_W-1:0] w_unused_po;
   assign w_po_en     = 1'b0;
   assign w_po_data   = '0;
   assign w_unused_po = bus.cut_po;
`endif

   assign w_lfsr_stepped = {^(r_lfsr & LFSR_TAPS[LFSR_W-1:0]), r_lfsr[LFSR_W-1:1]};
   // Patterns still to load; the segment with pat_idx == N only unloads.
   assign w_loading      = (r_pat_idx < {1'b0, r_n_lat});

   always_comb begin
      w_state_next   = r_state;
      w_lfsr_next    = r_lfsr;
      w_bit_cnt_next = r_bit_cnt;
      w_pat_idx_next = r_pat_idx;
      w_n_next       = r_n_lat;
      w_accept       = 1'b0;
      w_misr_en      = 1'b0;
      w_misr_clr     = 1'b0;
      w_misr_data    = {{(MISR_W-1){1'b0}}, bus.scan_out};
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_accept       = 1'b1;
               w_n_next       = bus.num_patterns;
               w_lfsr_next    = LFSR_SEED;
               w_misr_clr     = 1'b1;
               w_bit_cnt_next = '0;
               w_pat_idx_next = '0;
               w_state_next   = (bus.num_patterns == '0) ? S_COMPARE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_loading) begin
               w_lfsr_next = w_lfsr_stepped;
            end
            w_misr_en = (r_pat_idx != '0);
            if (r_bit_cnt == LAST_BIT) begin
               w_bit_cnt_next = '0;
               w_state_next   = w_loading ? S_CAPTURE : S_COMPARE;
            end else begin
               w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
            end
         end
         S_CAPTURE: begin
            w_lfsr_next    = w_lfsr_stepped;
            w_pat_idx_next = r_pat_idx + (PAT_W+1)'(1);
            w_misr_en      = w_po_en;
            w_misr_data    = w_po_data;
            w_state_next   = S_SHIFT;
         end
         S_COMPARE: begin
            w_state_next = S_DONE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      w_loading_next = (w_pat_idx_next < {1'b0, w_n_next});
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Outputs are registered from next-state values so they line up with the state.
   always_ff @(posedge CK) begin
      if (RST) begin
         r_lfsr    <= LFSR_SEED;
         r_bit_cnt <= '0;
         r_pat_idx <= '0;
         r_n_lat   <= '0;
         r_golden  <= '0;
         r_scan_en <= 1'b0;
         r_scan_in <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_cut_pi  <= '0;
      end else begin
         r_lfsr    <= w_lfsr_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_pat_idx <= w_pat_idx_next;
         r_n_lat   <= w_n_next;
         if (w_accept) begin
            r_golden <= bus.golden;
         end
         r_scan_en <= (w_state_next == S_SHIFT);
         r_scan_in <= (w_state_next == S_SHIFT) && w_loading_next && w_lfsr_next[0];
         r_busy    <= (w_state_next == S_SHIFT) || (w_state_next == S_CAPTURE) ||
                      (w_state_next == S_COMPARE);
         r_done    <= (w_state_next == S_DONE);
         if (w_state_next == S_CAPTURE) begin
            r_cut_pi <= w_lfsr_next[PI_W-1:0];
         end
         if (w_accept) begin
            r_pass <= 1'b0;
         end else if (r_state == S_COMPARE) begin
            r_pass <= (w_sig == r_golden);
         end
      end
   end

   lbist_misr #(
      .W (MISR_W)
   ) u_misr (
      .clk (CK),
      .rst (RST),
      .clr (w_misr_clr),
      .en  (w_misr_en),
      .din (w_misr_data),
      .sig (w_sig)
   );

   assign bus.scan_en   = r_scan_en;
   assign bus.scan_in   = r_scan_in;
   assign bus.cut_pi    = r_cut_pi;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.signature = w_sig;
endmodule
`default_nettype wire

// File: tb/tb_lbist_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lbist_sequencer
//  Purpose  : Directed bench for lbist_sequencer with a 6-flop scan core model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lbist_sequencer;
   localparam int PI_W = 7, PO_W = 7, MW = 16, PW = 10;

   logic       CK  = 1'b0;
   logic       RST = 1'b1;
   int         n_vec  = 0;
   int         n_miss = 0;
   logic [5:0] ch = 6'b0;
   int         shift_cnt = 0;
   bit         flip_en  = 1'b0;
   bit         stuck_en = 1'b0;

   lbist_sequencer_if #(.PI_W(PI_W), .PO_W(PO_W), .MISR_W(MW), .PAT_W(PW)) bus ();

   lbist_sequencer #(
      .CHAIN_LEN (6), .PI_W (PI_W), .PO_W (PO_W), .LFSR_W (16),
      .MISR_W (MW), .PAT_W (PW), .LFSR_SEED (16'hACE1)
   ) dut (
      .CK  (CK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CK = ~CK;

   function automatic logic [6:0] core_po(input logic [5:0] c, input logic [6:0] pi);
      return {c[5] ^ pi[6], c ^ pi[5:0]};
   endfunction

   function automatic logic [5:0] core_cap(input logic [5:0] c, input logic [6:0] pi);
      return ({c[4:0], c[5]} ^ pi[5:0]) ^ {6{pi[6] & c[0]}};
   endfunction

   // Scan core: shifts when scan_en, otherwise captures its next state.
   assign bus.scan_out = ch[5] ^ (flip_en && (shift_cnt == 32));
   assign bus.cut_po   = core_po(ch, bus.cut_pi) | {6'b0, stuck_en};

   always @(posedge CK) begin
      if (bus.scan_en) ch <= {ch[4:0], bus.scan_in};
      else             ch <= core_cap(ch, bus.cut_pi);
      if (bus.start && !bus.busy) shift_cnt <= 0;
      else if (bus.scan_en)       shift_cnt <= shift_cnt + 1;
   end

   function automatic logic [15:0] lstep(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   function automatic logic [15:0] mstep(input logic [15:0] m, input logic [15:0] d);
      return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ d;
   endfunction

   // Expected signature for an N-pattern run, with optional injected faults.
   function automatic logic [15:0] model_sig(input int n, input bit flip, input bit stuck);
      logic [15:0] l;
      logic [15:0] m;
      logic [5:0]  c;
      logic [6:0]  pi;
      logic [6:0]  po;
      logic        so;
      l = 16'hACE1;
      m = 16'h0000;
      c = 6'b0;
      for (int s = 0; s <= n; s++) begin
         for (int b = 0; b < 6; b++) begin
            so = c[5] ^ (flip && s == 5 && b == 2);
            if (s > 0) m = mstep(m, {15'b0, so});
            c = {c[4:0], (s < n) ? l[0] : 1'b0};
            if (s < n) l = lstep(l);
         end
         if (s < n) begin
            pi = l[6:0];
            po = core_po(c, pi) | {6'b0, stuck};
`ifdef LBIST_PO_COMPACT_EN
            m = mstep(m, {9'b0, po});
`else
            po = po ^ po;
`endif
            c = core_cap(c, pi);
            l = lstep(l);
         end
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start at the current negedge (cycle 0); dc = first cycle with done=1, -1 on timeout.
   task automatic run(input int n, input logic [15:0] g, input int pulse_at, output int dc);
      bus.num_patterns = PW'(n);
      bus.golden       = g;
      bus.start        = 1'b1;
      dc = -1;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge CK);
         bus.start = (c == pulse_at);
         if (bus.done) begin
            dc = c;
            break;
         end
      end
      bus.start = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] en_vec, done_vec, busy_vec;
      logic [15:0] g;
      int          dc;

      bus.start = 1'b0;
      bus.num_patterns = '0;
      bus.golden = '0;
      RST = 1'b1;
      repeat (2) @(negedge CK);
      chk("rst_scan_en", bus.scan_en, 0);
      chk("rst_scan_in", bus.scan_in, 0);
      chk("rst_cut_pi", bus.cut_pi, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_pass", bus.pass, 0);
      chk("rst_signature", bus.signature, 0);
      RST = 1'b0;
      @(negedge CK);

      // N=1 cycle-exact shift/capture/compare timeline
      en_vec = '0; done_vec = '0; busy_vec = '0;
      g = model_sig(1, 1'b0, 1'b0);
      bus.num_patterns = 10'd1;
      bus.golden = g;
      bus.start = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge CK);
         bus.start = 1'b0;
         en_vec[c]   = bus.scan_en;
         done_vec[c] = bus.done;
         busy_vec[c] = bus.busy;
      end
      chk("n1_scan_en_timeline", en_vec, 32'h0000_3F7E);
      chk("n1_done_timeline", done_vec, 32'h0000_8000);
      chk("n1_busy_timeline", busy_vec, 32'h0000_7FFE);
      chk("n1_pass", bus.pass, 1);
      chk("n1_signature", bus.signature, g);

      run(0, 16'h0000, 0, dc);
      chk("n0_done_cycle", dc, 2);
      chk("n0_pass_golden0", bus.pass, 1);
      chk("n0_signature", bus.signature, 0);
      run(0, 16'h0001, 0, dc);
      chk("n0_done_cycle_g1", dc, 2);
      chk("n0_pass_golden1", bus.pass, 0);

      g = model_sig(20, 1'b0, 1'b0);
      run(20, g, 0, dc);
      chk("n20_done_cycle", dc, 21*6 + 20 + 2);
      chk("n20_pass", bus.pass, 1);
      chk("n20_signature", bus.signature, g);
      repeat (3) @(negedge CK);
      chk("n20_done_sticky", bus.done, 1);
      chk("n20_signature_stable", bus.signature, g);

      flip_en = 1'b1;
      run(20, g, 0, dc);
      flip_en = 1'b0;
      chk("flip_signature", bus.signature, model_sig(20, 1'b1, 1'b0));
      chk("flip_pass", bus.pass, (model_sig(20, 1'b1, 1'b0) == g) ? 1 : 0);

      g = model_sig(3, 1'b0, 1'b0);
      run(3, g, 5, dc);
      chk("busy_start_done_cycle", dc, 4*6 + 3 + 2);
      chk("busy_start_pass", bus.pass, 1);

      // Reset in the middle of a SHIFT segment
      bus.num_patterns = 10'd5;
      bus.golden = 16'h0000;
      bus.start = 1'b1;
      repeat (3) @(negedge CK);
      bus.start = 1'b0;
      chk("pre_rst_scan_en", bus.scan_en, 1);
      RST = 1'b1;
      @(negedge CK);
      RST = 1'b0;
      chk("midrst_scan_en", bus.scan_en, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_pass", bus.pass, 0);

      g = model_sig(20, 1'b0, 1'b0);
      stuck_en = 1'b1;
      run(20, g, 0, dc);
      stuck_en = 1'b0;
      chk("po_stuck_signature", bus.signature, model_sig(20, 1'b0, 1'b1));
      chk("po_stuck_pass", bus.pass, (model_sig(20, 1'b0, 1'b1) == g) ? 1 : 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
`default_nettype wire
